// File: rtl/envelope_pair_serializer.sv
// Buffers (max, min) peak-detect pairs in a small FIFO and re-emits each pair
// as two ordered 8-bit samples on a valid/ready stream, with order checking.
module envelope_pair_serializer #(
    parameter int DEPTH     = 4,
    parameter bit MAX_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_max,
    input  logic [7:0]               in_min,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_is_max,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     order_err,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         pair_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       hold_max_q, hold_max_d, hold_min_q, hold_min_d;
    logic             phase_q, phase_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_is_max_q, out_is_max_d;
    logic             order_err_q, order_err_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
    logic             push_s, pop_s, swap_s, fifo_ne_s;

    assign in_ready   = (level_q != FULL_LVL);
    assign fifo_level = level_q;
    assign out_valid  = hold_valid_q;
    assign out_data   = out_data_q;
    assign out_is_max = out_is_max_q;
    assign order_err  = order_err_q;
    assign pair_cnt   = pair_cnt_q;

    // Next-state: FIFO push/pop, hold-stage sequencing, error flag and counter.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        hold_valid_d = hold_valid_q;
        hold_max_d   = hold_max_q;
        hold_min_d   = hold_min_q;
        phase_d      = phase_q;
        order_err_d  = order_err_q;
        pair_cnt_d   = pair_cnt_q;
        out_data_d   = 8'h00;
        out_is_max_d = 1'b0;
        pop_s        = 1'b0;

        push_s    = in_valid && (level_q != FULL_LVL);
        swap_s    = (in_max < in_min);
        fifo_ne_s = (level_q != {LVL_W{1'b0}});

        if (push_s) begin
            mem_d[wr_ptr_q] = swap_s ? {in_min, in_max} : {in_max, in_min};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // A finished pair is replaced in the same edge so pairs stream with no bubble.
        if (!hold_valid_q) begin
            pop_s = fifo_ne_s;
        end else if (out_ready) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                pair_cnt_d = pair_cnt_q + CNT_W'(1);
                if (fifo_ne_s) begin
                    pop_s = 1'b1;
                end else begin
                    hold_valid_d = 1'b0;
                    phase_d      = 1'b0;
                end
            end
        end else begin
            phase_d = phase_q;
        end

        if (pop_s) begin
            {hold_max_d, hold_min_d} = mem_q[rd_ptr_q];
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            hold_valid_d = 1'b1;
            phase_d      = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (push_s && swap_s) begin
            order_err_d = 1'b1;
        end else if (err_clr) begin
            order_err_d = 1'b0;
        end else begin
            order_err_d = order_err_q;
        end

        if (hold_valid_d) begin
            out_is_max_d = phase_d ? ~MAX_FIRST : MAX_FIRST;
            out_data_d   = out_is_max_d ? hold_max_d : hold_min_d;
        end else begin
            out_is_max_d = 1'b0;
            out_data_d   = 8'h00;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            level_q      <= {LVL_W{1'b0}};
            hold_valid_q <= 1'b0;
            hold_max_q   <= 8'h00;
            hold_min_q   <= 8'h00;
            phase_q      <= 1'b0;
            out_data_q   <= 8'h00;
            out_is_max_q <= 1'b0;
            order_err_q  <= 1'b0;
            pair_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            hold_valid_q <= hold_valid_d;
            hold_max_q   <= hold_max_d;
            hold_min_q   <= hold_min_d;
            phase_q      <= phase_d;
            out_data_q   <= out_data_d;
            out_is_max_q <= out_is_max_d;
            order_err_q  <= order_err_d;
            pair_cnt_q   <= pair_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_envelope_pair_serializer.sv
// Self-checking bench for envelope_pair_serializer: directed steps plus a
// randomized run against a pair-queue reference model and sample scoreboard.
module tb_envelope_pair_serializer;
    localparam int DEPTH = 4;
    localparam bit MF    = 1'b0;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, err_clr;
    logic [7:0]  in_max, in_min, out_data;
    logic        in_ready, out_is_max, out_valid, order_err;
    logic [2:0]  fifo_level;
    logic [15:0] pair_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] fq[$];
    logic [8:0]  sb[$];
    bit          m_hv, m_ph, m_err;
    logic [7:0]  m_hmax, m_hmin;
    int          m_cnt, accepted;

    envelope_pair_serializer #(.DEPTH(DEPTH), .MAX_FIRST(MF), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_max(in_max), .in_min(in_min), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_is_max(out_is_max),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .order_err(order_err), .err_clr(err_clr), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        sb.delete();
        m_hv = 0; m_ph = 0; m_err = 0; m_cnt = 0;
    endtask

    // Check outputs against the model, advance the model over one edge, then step.
    task automatic tick();
        bit       acc;
        bit       exp_is_max;
        logic [7:0] hi, lo;
        logic [8:0] s;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_hv});
        if (m_hv) begin
            exp_is_max = (m_ph == 1'b0) ? MF : !MF;
            chk("out_is_max", {31'd0, out_is_max}, {31'd0, exp_is_max});
            chk("out_data", {24'd0, out_data}, {24'd0, exp_is_max ? m_hmax : m_hmin});
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, fq.size() != DEPTH});
        chk("fifo_level", {29'd0, fifo_level}, fq.size());
        chk("order_err", {31'd0, order_err}, {31'd0, m_err});
        chk("pair_cnt", {16'd0, pair_cnt}, m_cnt & 32'hFFFF);
        if (out_valid && out_ready && !rst) begin
            if (sb.size() == 0) begin
                chk("sb_extra", {23'd0, out_is_max, out_data}, 32'h1FF);
            end else begin
                s = sb.pop_front();
                chk("sb_sample", {23'd0, out_is_max, out_data}, {23'd0, s});
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            acc = in_valid && (fq.size() != DEPTH);
            if (!m_hv) begin
                if (fq.size() > 0) begin
                    {m_hmax, m_hmin} = fq.pop_front(); m_hv = 1; m_ph = 0;
                end
            end else if (out_ready) begin
                if (!m_ph) m_ph = 1;
                else begin
                    m_cnt++;
                    if (fq.size() > 0) begin
                        {m_hmax, m_hmin} = fq.pop_front(); m_ph = 0;
                    end else begin
                        m_hv = 0; m_ph = 0;
                    end
                end
            end
            if (acc) begin
                hi = (in_max < in_min) ? in_min : in_max;
                lo = (in_max < in_min) ? in_max : in_min;
                fq.push_back({hi, lo});
                accepted++;
                if (MF == 1'b0) begin sb.push_back({1'b0, lo}); sb.push_back({1'b1, hi}); end
                else            begin sb.push_back({1'b1, hi}); sb.push_back({1'b0, lo}); end
                if (in_max < in_min) m_err = 1;
            end else if (err_clr) begin
                m_err = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; err_clr = 0; in_max = 0; in_min = 0;
        accepted = 0;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_is_max", {31'd0, out_is_max}, 0);
        chk("rst_level", {29'd0, fifo_level}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_pair_cnt", {16'd0, pair_cnt}, 0);
        rst = 0;

        // 1: single pair, latency and order
        out_ready = 1; in_valid = 1; in_max = 8'hC8; in_min = 8'h10;
        tick();
        in_valid = 0;
        tick();
        chk("t1_valid", {31'd0, out_valid}, 1);
        chk("t1_s0", {23'd0, out_is_max, out_data}, 32'h010);
        tick();
        chk("t1_s1", {23'd0, out_is_max, out_data}, 32'h1C8);
        tick();
        chk("t1_cnt", {16'd0, pair_cnt}, 1);
        chk("t1_drop", {31'd0, out_valid}, 0);

        // 2: fill with output stalled, then drain back-to-back
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_max = 8'(8'h90 + i); in_min = 8'(8'h01 + i);
            tick();
        end
        chk("t2_level", {29'd0, fifo_level}, 4);
        chk("t2_full", {31'd0, in_ready}, 0);
        in_max = 8'hEE; in_min = 8'h0E;
        tick();
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            chk("t2_nogap", {31'd0, out_valid}, 1);
            tick();
        end
        chk("t2_cnt", {16'd0, pair_cnt}, 6);
        chk("t2_empty", {31'd0, out_valid}, 0);

        // 3: order error, clear, and set-wins
        in_valid = 1; in_max = 8'h20; in_min = 8'h80;
        tick();
        in_valid = 0;
        chk("t3_err", {31'd0, order_err}, 1);
        tick();
        chk("t3_s0", {23'd0, out_is_max, out_data}, 32'h020);
        tick();
        chk("t3_s1", {23'd0, out_is_max, out_data}, 32'h180);
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("t3_clr", {31'd0, order_err}, 0);
        in_valid = 1; err_clr = 1; in_max = 8'h05; in_min = 8'h06;
        tick();
        in_valid = 0; err_clr = 0;
        chk("t3_setwins", {31'd0, order_err}, 1);
        for (int i = 0; i < 4; i++) tick();

        // 4: stall mid-pair
        out_ready = 0; in_valid = 1; in_max = 8'h5B; in_min = 8'hA0;
        tick();
        in_valid = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold", {23'd0, out_is_max, out_data}, 32'h05B);
            tick();
        end
        out_ready = 1;
        tick();
        chk("t4_resume", {23'd0, out_is_max, out_data}, 32'h1A0);
        tick();

        // 5: random traffic, 1000 pairs
        accepted = 0;
        in_valid = 1;
        for (int c = 0; c < 20000 && accepted < 1000; c++) begin
            in_max = 8'($urandom_range(0, 255));
            in_min = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            chk("t5_level_bound", {31'd0, fifo_level <= 3'd4}, 1);
            tick();
        end
        chk("t5_accepted", accepted, 1000);
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 50 && (sb.size() != 0 || m_hv); c++) tick();
        chk("t5_drained", sb.size(), 0);

        // 6: reset mid-pair with pairs queued
        err_clr = 1; tick(); err_clr = 0;
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_max = 8'(8'hC0 + i); in_min = 8'(8'h30 + i);
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0; rst = 1;
        tick();
        rst = 0;
        chk("t6_valid", {31'd0, out_valid}, 0);
        chk("t6_level", {29'd0, fifo_level}, 0);
        chk("t6_cnt", {16'd0, pair_cnt}, 0);
        out_ready = 1; in_valid = 1; in_max = 8'h77; in_min = 8'h33;
        tick();
        in_valid = 0;
        tick();
        chk("t6_s0", {23'd0, out_is_max, out_data}, 32'h033);
        tick();
        chk("t6_s1", {23'd0, out_is_max, out_data}, 32'h177);
        tick();
        chk("t6_cnt1", {16'd0, pair_cnt}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
